// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: pixel width, sequencer states and latch-gap timing.
package ws2812_pkg;

  localparam int PIXEL_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    LATCH
  } state_t;

  // Number of clock cycles the line must stay idle to latch a frame.
  function automatic int latch_cycles(input int f_clk, input int reset_us);
    return (f_clk / 1_000_000) * reset_us;
  endfunction

endpackage

// File: rtl/ws2812_frame_sequencer_if.sv
// Pixel handoff between the frame sequencer (master) and the bit controller (slave).
interface ws2812_frame_sequencer_if;
  import ws2812_pkg::*;

  logic [PIXEL_W-1:0] pixel_data;
  logic               pixel_load;
  logic               pixel_done;

  modport master (output pixel_data, output pixel_load, input pixel_done);
  modport slave  (input pixel_data, input pixel_load, output pixel_done);

endinterface

// File: rtl/ws2812_pixel_buffer.sv
// Frame buffer: one GRB word per pixel, synchronous write, combinational read.
module ws2812_pixel_buffer
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS = 8,
  parameter int ADDR_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  logic [PIXEL_W-1:0] mem_q [NUM_PIXELS];
  logic [PIXEL_W-1:0] mem_d [NUM_PIXELS];

  // Write decode; addresses past the last pixel match no entry and are dropped.
  always_comb begin
    for (int i = 0; i < NUM_PIXELS; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Read mux; an unmatched address reads as zero rather than indexing off the end.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

  // Storage; cleared to black on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Feeds a frame of pixels to the WS2812 bit controller one word at a time,
// then holds the line idle for the latch gap and reports frame_done.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int F_CLK      = 50_000_000,
  parameter int NUM_PIXELS = 8,
  parameter int RESET_US   = 80,
  parameter int ADDR_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [PIXEL_W-1:0]    wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  ws2812_frame_sequencer_if.master pix
);

  localparam int                 LATCH_CYCLES = latch_cycles(F_CLK, RESET_US);
  localparam int                 CNT_W        = $clog2(LATCH_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  IDX_LAST     = ADDR_W'(NUM_PIXELS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                pixel_load_q, pixel_load_d;
  logic [PIXEL_W-1:0]  pixel_data_q, pixel_data_d;
  logic [PIXEL_W-1:0]  rd_data;

  // The buffer is addressed with the next index so the word is captured on
  // the same edge that enters LOAD; a same-edge write therefore reads old data.
  ws2812_pixel_buffer #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

  // Next state, pixel index, latch counter and busy flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        if (pix.pixel_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = LATCH;
            cnt_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      LATCH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs derived from the state being entered.
  always_comb begin
    pixel_load_d = 1'b0;
    pixel_data_d = pixel_data_q;
    if (state_d == LOAD) begin
      pixel_load_d = 1'b1;
      pixel_data_d = rd_data;
    end
    frame_done_d = (state_d == LATCH) && (cnt_d == CNT_LAST);
  end

  // All sequencer state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pixel_load_q <= 1'b0;
      pixel_data_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pixel_load_q <= pixel_load_d;
      pixel_data_q <= pixel_data_d;
    end
  end

  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign pix.pixel_load = pixel_load_q;
  assign pix.pixel_data = pixel_data_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench: 4-pixel sequencer checked every cycle against a frame-level model,
// plus a 1-pixel build checked with hand-computed timing.
module tb_ws2812_frame_sequencer;
  import ws2812_pkg::*;

  localparam int N = 4;
  localparam int L = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // 4-pixel DUT
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        start = 1'b0;
  logic        busy, frame_done;
  logic        done_stub = 1'b0, done_spur = 1'b0;
  ws2812_frame_sequencer_if pix_if();
  assign pix_if.pixel_done = done_stub | done_spur;

  ws2812_frame_sequencer #(.F_CLK(50_000_000), .NUM_PIXELS(N), .RESET_US(80)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .frame_done(frame_done), .pix(pix_if));

  // 1-pixel DUT
  logic        wr_en1 = 1'b0;
  logic [0:0]  wr_addr1 = '0;
  logic [23:0] wr_data1 = '0;
  logic        start1 = 1'b0;
  logic        busy1, frame_done1;
  logic        done_stub1 = 1'b0;
  ws2812_frame_sequencer_if pix1_if();
  assign pix1_if.pixel_done = done_stub1;

  ws2812_frame_sequencer #(.F_CLK(50_000_000), .NUM_PIXELS(1), .RESET_US(80)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .busy(busy1), .frame_done(frame_done1), .pix(pix1_if));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- frame-level reference model (4-pixel DUT) ----------------
  logic [23:0] mbuf [N];
  bit          m_active = 0;   // a frame is in progress
  bit          m_in_load = 0;  // the current cycle is a load cycle
  int          m_idx = 0;      // pixel most recently handed over
  int          m_latch = 0;    // 0: not in gap, else 1-based position in the gap
  logic        exp_load = 0, exp_busy = 0, exp_fd = 0;
  logic [23:0] exp_data = '0;

  initial begin
    foreach (mbuf[i]) mbuf[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        foreach (mbuf[i]) mbuf[i] = '0;
        m_active = 0; m_in_load = 0; m_idx = 0; m_latch = 0;
        exp_load = 0; exp_busy = 0; exp_fd = 0; exp_data = '0;
      end else begin
        exp_load = 0;
        exp_fd   = 0;
        if (!m_active) begin
          if (start) begin
            m_active = 1; m_idx = 0; m_in_load = 1;
            exp_load = 1; exp_data = mbuf[0];
          end
        end else if (m_in_load) begin
          m_in_load = 0;
        end else if (m_latch == 0) begin
          if (pix_if.pixel_done) begin
            if (m_idx < N - 1) begin
              m_idx++; m_in_load = 1;
              exp_load = 1; exp_data = mbuf[m_idx];
            end else begin
              m_latch = 1;
              exp_fd = (L == 1);
            end
          end
        end else if (m_latch == L) begin
          m_active = 0; m_latch = 0;
        end else begin
          m_latch++;
          exp_fd = (m_latch == L);
        end
        exp_busy = m_active;
        if (wr_en && int'(wr_addr) < N) mbuf[wr_addr] = wr_data;
      end
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  int          cyc = 0;
  int          load_cyc[$], fd_cyc[$], load1_cyc[$], fd1_cyc[$];
  logic [23:0] load_dat[$], load1_dat[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    chk("busy", busy, exp_busy);
    chk("frame_done", frame_done, exp_fd);
    chk("pixel_load", pix_if.pixel_load, exp_load);
    chk("pixel_data", pix_if.pixel_data, exp_data);
    if (pix_if.pixel_load) begin
      load_cyc.push_back(cyc);
      load_dat.push_back(pix_if.pixel_data);
      $display("cycle %0d: load data=%06h", cyc, pix_if.pixel_data);
    end
    if (frame_done) begin
      fd_cyc.push_back(cyc);
      $display("cycle %0d: frame_done", cyc);
    end
    if (pix1_if.pixel_load) begin
      load1_cyc.push_back(cyc);
      load1_dat.push_back(pix1_if.pixel_data);
      $display("cycle %0d: n1 load data=%06h", cyc, pix1_if.pixel_data);
    end
    if (frame_done1) begin
      fd1_cyc.push_back(cyc);
      $display("cycle %0d: n1 frame_done", cyc);
    end
  end

  // ---------------- bit-controller stubs: pixel_done 30 cycles after load ----------------
  int cd = 0, cd1 = 0;
  initial forever begin
    @(negedge clk);
    done_stub = 1'b0;
    if (!rst_n) cd = 0;
    else begin
      if (cd > 0) begin cd--; if (cd == 0) done_stub = 1'b1; end
      if (pix_if.pixel_load) cd = 30;
    end
  end
  initial forever begin
    @(negedge clk);
    done_stub1 = 1'b0;
    if (!rst_n) cd1 = 0;
    else begin
      if (cd1 > 0) begin cd1--; if (cd1 == 0) done_stub1 = 1'b1; end
      if (pix1_if.pixel_load) cd1 = 30;
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic tick(); @(negedge clk); endtask

  task automatic wr(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_load(input int budget);
    int t = 0;
    while (!pix_if.pixel_load && t < budget) begin tick(); t++; end
    chk("load_timeout", pix_if.pixel_load, 1'b1);
  endtask

  task automatic wait_fd(input int budget);
    int t = 0;
    while (fd_cyc.size() < 1 && t < budget) begin tick(); t++; end
    chk("frame_done_timeout", fd_cyc.size() >= 1, 1'b1);
    tick(); tick();
  endtask

  task automatic clear_log();
    load_cyc.delete(); load_dat.delete(); fd_cyc.delete();
  endtask

  task automatic check_frame(input logic [23:0] w0, w1, w2, w3);
    logic [23:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    chk("load_count", load_cyc.size(), 4);
    if (load_cyc.size() == 4 && fd_cyc.size() >= 1) begin
      for (int i = 0; i < 4; i++) chk($sformatf("load%0d_data", i), load_dat[i], w[i]);
      for (int i = 1; i < 4; i++) chk($sformatf("load%0d_gap", i), load_cyc[i] - load_cyc[i-1], 31);
      chk("latch_gap", fd_cyc[0] - load_cyc[3], 30 + L);
    end
    chk("busy_after_frame", busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_pixel_data", pix_if.pixel_data, 24'h0);
    chk("rst_pixel_load", pix_if.pixel_load, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();

    // Frame 1: basic ordering and timing
    wr(2'd0, 24'h00FF00); wr(2'd1, 24'hFF0000); wr(2'd2, 24'h0000FF); wr(2'd3, 24'h123456);
    clear_log();
    pulse_start();
    wait_fd(6000);
    check_frame(24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h123456);

    // Frame 2: spurious pixel_done in IDLE/LOAD, start in WAIT/LATCH, live write
    done_spur = 1'b1; tick(); done_spur = 1'b0; tick();
    clear_log();
    pulse_start();
    wait_load(5);
    done_spur = 1'b1; tick(); done_spur = 1'b0;
    repeat (5) tick();
    pulse_start();
    wait_load(40);
    repeat (3) tick();
    wr(2'd3, 24'hABCDEF);
    wait_load(40); tick();
    wait_load(40);
    repeat (100) tick();
    pulse_start();
    wait_fd(6000);
    check_frame(24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hABCDEF);

    // Frame 3: reset in the middle of the latch gap
    clear_log();
    pulse_start();
    wait_load(5); tick();
    for (int i = 0; i < 3; i++) begin wait_load(40); tick(); end
    repeat (2030) tick();
    chk("pre_reset_busy", busy, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_frame_done", frame_done, 1'b0);
    chk("async_rst_pixel_load", pix_if.pixel_load, 1'b0);
    chk("async_rst_pixel_data", pix_if.pixel_data, 24'h0);
    repeat (3) tick();
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    clear_log();
    pulse_start();
    wait_fd(6000);
    check_frame(24'h0, 24'h0, 24'h0, 24'h0);

    // Random traffic: writes, starts and stray pixel_done, model-checked
    clear_log();
    t = 0;
    while (fd_cyc.size() < 2 && t < 20000) begin
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = 2'($urandom);
      wr_data   = 24'($urandom);
      start     = ($urandom_range(0, 59) == 0);
      done_spur = ($urandom_range(0, 49) == 0);
      tick();
      t++;
    end
    wr_en = 1'b0; start = 1'b0; done_spur = 1'b0;
    chk("random_frames_done", fd_cyc.size() >= 2, 1'b1);
    $display("random phase: %0d loads, %0d frames", load_cyc.size(), fd_cyc.size());
    t = 0;
    while (busy && t < 6000) begin tick(); t++; end

    // 1-pixel build: out-of-range write dropped, start held through frame_done
    wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_data1 = 24'h5A5A5A; tick();
    wr_addr1 = 1'b1; wr_data1 = 24'h111111; tick();
    wr_en1 = 1'b0;
    load1_cyc.delete(); load1_dat.delete(); fd1_cyc.delete();
    start1 = 1'b1;
    t = 0;
    while (!frame_done1 && t < 6000) begin tick(); t++; end
    chk("n1_frame_done_seen", frame_done1, 1'b1);
    chk("n1_busy_at_done", busy1, 1'b1);
    tick();
    chk("n1_busy_idle_cycle", busy1, 1'b0);
    chk("n1_no_load_idle_cycle", pix1_if.pixel_load, 1'b0);
    tick();
    chk("n1_second_load", pix1_if.pixel_load, 1'b1);
    chk("n1_second_data", pix1_if.pixel_data, 24'h5A5A5A);
    chk("n1_busy_again", busy1, 1'b1);
    start1 = 1'b0;
    tick();
    chk("n1_load_count", load1_cyc.size(), 2);
    if (load1_cyc.size() == 2 && fd1_cyc.size() >= 1) begin
      chk("n1_first_data", load1_dat[0], 24'h5A5A5A);
      chk("n1_latch_gap", fd1_cyc[0] - load1_cyc[0], 30 + L);
      chk("n1_restart_gap", load1_cyc[1] - fd1_cyc[0], 2);
    end
    t = 0;
    while (fd1_cyc.size() < 2 && t < 6000) begin tick(); t++; end
    chk("n1_second_frame_done", fd1_cyc.size(), 2);
    repeat (2) tick();
    chk("n1_idle_after", busy1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
